// File: rtl/dct_1d_sequencer_pkg.sv
// Shared constants and FSM encoding for the 1-D DCT sequencer and its core interface.
package dct_1d_sequencer_pkg;

  localparam int unsigned DCT_N     = 8;
  localparam int unsigned DCT_OUT_W = 12;

  localparam logic [1:0] CORE_LOAD    = 2'd0;
  localparam logic [1:0] CORE_COMPUTE = 2'd1;
  localparam logic [1:0] CORE_CAPTURE = 2'd2;
  localparam logic [1:0] CORE_DRAIN   = 2'd3;

  typedef enum logic [2:0] {
    StCoreClr,
    StLoad,
    StCompute,
    StCapture,
    StDrain
  } seq_state_e;

endpackage

// File: rtl/dct_1d_sequencer_if.sv
// Sample input stream (valid/ready) and coefficient output stream (valid-only) of the sequencer.
interface dct_1d_sequencer_if
  import dct_1d_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned OUT_W  = DCT_OUT_W
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic [OUT_W-1:0]  out_data;
  logic [2:0]        out_index;
  logic              out_last;

  modport master (
    output in_valid, in_data,
    input  in_ready, out_valid, out_data, out_index, out_last
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, out_valid, out_data, out_index, out_last
  );
endinterface

// File: rtl/dct_1d_sequencer.sv
// Block controller for the 8-point Loeffler DCT core: load, compute, capture, drain, core clear.
module dct_1d_sequencer
  import dct_1d_sequencer_pkg::*;
#(
  parameter int unsigned N              = DCT_N,
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned OUT_W          = DCT_OUT_W,
  parameter int unsigned COMPUTE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rstn,
  dct_1d_sequencer_if.slave bus,
  output logic              core_rstn,
  output logic [1:0]        core_state,
  output logic [DATA_W-1:0] core_in,
  input  logic [OUT_W-1:0]  core_out,
  output logic              busy
);

  localparam int unsigned      CompW     = $clog2(COMPUTE_CYCLES + 1);
  localparam logic [3:0]       LoadLast  = 4'(N - 1);
  localparam logic [3:0]       LoadFull  = 4'(N);
  localparam logic [2:0]       DrainLast = 3'(N - 1);
  localparam logic [CompW-1:0] CompLast  = CompW'(COMPUTE_CYCLES - 1);

  seq_state_e       state_q, state_d;
  logic [3:0]       load_cnt_q, load_cnt_d;
  logic [CompW-1:0] comp_cnt_q, comp_cnt_d;
  logic [2:0]       drain_cnt_q, drain_cnt_d;
  logic             out_valid_q;
  logic [2:0]       out_index_q;
  logic             in_ready;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= StCoreClr;
      load_cnt_q  <= '0;
      comp_cnt_q  <= '0;
      drain_cnt_q <= '0;
      out_valid_q <= 1'b0;
      out_index_q <= '0;
    end else begin
      state_q     <= state_d;
      load_cnt_q  <= load_cnt_d;
      comp_cnt_q  <= comp_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      // Core registers its output, so the coefficient stream trails DRAIN by one cycle.
      out_valid_q <= (state_q == StDrain);
      if (state_q == StDrain) out_index_q <= drain_cnt_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    load_cnt_d  = load_cnt_q;
    comp_cnt_d  = comp_cnt_q;
    drain_cnt_d = drain_cnt_q;
    in_ready    = 1'b0;
    core_state  = CORE_COMPUTE;
    unique case (state_q)
      StCoreClr: begin
        load_cnt_d = '0;
        state_d    = StLoad;
      end
      StLoad: begin
        in_ready = 1'b1;
        // The core writes its sample memory on every LOAD cycle, so only drive LOAD with data.
        if (bus.in_valid) begin
          core_state = CORE_LOAD;
          if (load_cnt_q != LoadFull) load_cnt_d = load_cnt_q + 4'd1;
          if (load_cnt_q == LoadLast) begin
            comp_cnt_d = '0;
            state_d    = StCompute;
          end
        end
      end
      StCompute: begin
        comp_cnt_d = comp_cnt_q + CompW'(1);
        if (comp_cnt_q == CompLast) state_d = StCapture;
      end
      StCapture: begin
        core_state  = CORE_CAPTURE;
        drain_cnt_d = '0;
        state_d     = StDrain;
      end
      StDrain: begin
        core_state  = CORE_DRAIN;
        drain_cnt_d = drain_cnt_q + 3'd1;
        if (drain_cnt_q == DrainLast) state_d = StCoreClr;
      end
      default: state_d = StCoreClr;
    endcase
  end

  assign core_rstn     = rstn & (state_q != StCoreClr);
  assign core_in       = bus.in_data;
  assign busy          = !((state_q == StLoad) && (load_cnt_q == 4'd0));
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = core_out;
  assign bus.out_index = out_index_q;
  assign bus.out_last  = out_valid_q && (out_index_q == 3'd7);

endmodule
